// File: rtl/lsu_pkg.sv
// Shared types and constants for the byte-wide load/store unit.
package lsu_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int RD_W   = 3;

    // Addresses from RO_BASE upward hold constants: readable, never writable.
    localparam logic [ADDR_W-1:0] RO_BASE = 8'd128;

    typedef enum logic [1:0] {
        IDLE,
        STORE,
        LOAD,
        RESP
    } lsu_state_t;

    typedef struct packed {
        logic              is_store;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] offset;
        logic [DATA_W-1:0] data;
        logic [RD_W-1:0]   rd;
    } lsu_req_t;

    function automatic logic is_read_only(input logic [ADDR_W-1:0] ea);
        return ea >= RO_BASE;
    endfunction

endpackage

// File: rtl/lsu_ea_check.sv
// Effective-address adder (8-bit wrap) and read-only region flag.
module lsu_ea_check
    import lsu_pkg::*;
(
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] offset,
    output logic [ADDR_W-1:0] ea,
    output logic              read_only
);

    assign ea        = base + offset;
    assign read_only = is_read_only(ea);

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding byte load/store unit between execute stage and data memory.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [ADDR_W-1:0] req_offset,
    input  logic [DATA_W-1:0] req_store_data,
    input  logic [RD_W-1:0]   req_rd,
    output logic              mem_write_en,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_base,
    output logic [ADDR_W-1:0] mem_offset,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              wb_valid,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              err_ro
);

    lsu_state_t        state, next_state;
    lsu_req_t          req_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [ADDR_W-1:0] ea;
    logic              read_only;

    lsu_ea_check u_ea_check (
        .base      (req_q.base),
        .offset    (req_q.offset),
        .ea        (ea),
        .read_only (read_only)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The request is only captured in IDLE, so anything presented while busy is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q <= '0;
        end else if (state == IDLE && req_valid) begin
            req_q <= '{is_store: req_is_store,
                       base:     req_base,
                       offset:   req_offset,
                       data:     req_store_data,
                       rd:       req_rd};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_data_q <= '0;
        end else if (state == LOAD) begin
            wb_data_q <= mem_data_out;
        end
    end

    always_comb begin
        next_state   = state;
        req_ready    = 1'b0;
        mem_write_en = 1'b0;
        mem_read_en  = 1'b0;
        mem_base     = '0;
        mem_offset   = '0;
        mem_data_in  = '0;
        wb_valid     = 1'b0;
        err_ro       = 1'b0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next_state = req_is_store ? STORE : LOAD;
                end
            end
            STORE: begin
                if (read_only) begin
                    err_ro = 1'b1;
                end else begin
                    mem_write_en = 1'b1;
                    mem_base     = req_q.base;
                    mem_offset   = req_q.offset;
                    mem_data_in  = req_q.data;
                end
                next_state = IDLE;
            end
            LOAD: begin
                mem_read_en = 1'b1;
                mem_base    = req_q.base;
                mem_offset  = req_q.offset;
                next_state  = RESP;
            end
            RESP: begin
                wb_valid   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase

        // Reset silences every output in the same cycle, before the state register clears.
        if (reset) begin
            req_ready    = 1'b0;
            mem_write_en = 1'b0;
            mem_read_en  = 1'b0;
            mem_base     = '0;
            mem_offset   = '0;
            mem_data_in  = '0;
            wb_valid     = 1'b0;
            err_ro       = 1'b0;
        end
    end

    assign wb_data = reset ? '0 : wb_data_q;
    assign wb_rd   = reset ? '0 : req_q.rd;

    // The region check assumes the read-only area is exactly the upper half of the map.
    always_comb begin
        if (!reset) begin
            assert (!(mem_write_en && mem_read_en));
            assert (read_only == ea[ADDR_W-1]);
            if (state == STORE || state == LOAD) begin
                assert (req_q.is_store == (state == STORE));
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 256-byte memory model.
module tb_load_store_unit;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_is_store;
    logic [7:0] req_base;
    logic [7:0] req_offset;
    logic [7:0] req_store_data;
    logic [2:0] req_rd;
    logic       mem_write_en;
    logic       mem_read_en;
    logic [7:0] mem_base;
    logic [7:0] mem_offset;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;
    logic       wb_valid;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic       err_ro;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] mem [256];
    logic       mem_init;
    logic [7:0] mem_addr;
    int         write_count;
    int         wb_count;
    int         write_mark;
    int         wb_mark;

    load_store_unit dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_store   (req_is_store),
        .req_base       (req_base),
        .req_offset     (req_offset),
        .req_store_data (req_store_data),
        .req_rd         (req_rd),
        .mem_write_en   (mem_write_en),
        .mem_read_en    (mem_read_en),
        .mem_base       (mem_base),
        .mem_offset     (mem_offset),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .err_ro         (err_ro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory is preloaded with addr ^ 0x5A so untouched locations have known contents.
    assign mem_addr     = mem_base + mem_offset;
    assign mem_data_out = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            write_count <= 0;
            wb_count    <= 0;
        end else begin
            if (mem_write_en) begin
                mem[mem_addr] <= mem_data_in;
                write_count   <= write_count + 1;
            end
            if (wb_valid) wb_count <= wb_count + 1;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input logic st, input logic [7:0] b,
                                  input logic [7:0] o, input logic [7:0] d, input logic [2:0] rd);
        req_valid      = v;
        req_is_store   = st;
        req_base       = b;
        req_offset     = o;
        req_store_data = d;
        req_rd         = rd;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset    = 1'b1;
        mem_init = 1'b1;
        apply_stimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0);
        next_cycle();
        next_cycle();

        check_output("rst_ready",    32'(req_ready),    0);
        check_output("rst_wen",      32'(mem_write_en), 0);
        check_output("rst_ren",      32'(mem_read_en),  0);
        check_output("rst_wb_valid", 32'(wb_valid),     0);
        check_output("rst_wb_data",  32'(wb_data),      0);
        check_output("rst_wb_rd",    32'(wb_rd),        0);
        check_output("rst_err_ro",   32'(err_ro),       0);

        mem_init = 1'b0;
        reset    = 1'b0;
        #1;
        check_output("post_rst_ready", 32'(req_ready), 1);

        // Store 0xA5 to 0x10+0x05
        apply_stimulus(1'b1, 1'b1, 8'h10, 8'h05, 8'hA5, 3'd0);
        check_output("st_ready_idle", 32'(req_ready), 1);
        next_cycle();
        apply_stimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0);
        check_output("st_wen",    32'(mem_write_en), 1);
        check_output("st_ren",    32'(mem_read_en),  0);
        check_output("st_base",   32'(mem_base),     32'h10);
        check_output("st_offset", 32'(mem_offset),   32'h05);
        check_output("st_data",   32'(mem_data_in),  32'hA5);
        check_output("st_err_ro", 32'(err_ro),       0);
        check_output("st_ready",  32'(req_ready),    0);
        next_cycle();
        check_output("st_wen_after", 32'(mem_write_en), 0);
        check_output("st_mem_15",    32'(mem[8'h15]),   32'hA5);

        // Load same address into r3
        apply_stimulus(1'b1, 1'b0, 8'h10, 8'h05, 8'h00, 3'd3);
        next_cycle();
        apply_stimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0);
        check_output("ld_ren",      32'(mem_read_en),  1);
        check_output("ld_wen",      32'(mem_write_en), 0);
        check_output("ld_base",     32'(mem_base),     32'h10);
        check_output("ld_offset",   32'(mem_offset),   32'h05);
        check_output("ld_wb_early", 32'(wb_valid),     0);
        next_cycle();
        check_output("ld_wb_valid", 32'(wb_valid),    1);
        check_output("ld_wb_rd",    32'(wb_rd),       3);
        check_output("ld_wb_data",  32'(wb_data),     32'hA5);
        check_output("ld_resp_ren", 32'(mem_read_en), 0);
        check_output("ld_resp_base", 32'(mem_base),   0);
        next_cycle();
        check_output("ld_wb_drop", 32'(wb_valid), 0);
        check_output("ld_wb_hold", 32'(wb_data),  32'hA5);

        // Wrapping store: 0xF0 + 0x20 -> EA 0x10
        apply_stimulus(1'b1, 1'b1, 8'hF0, 8'h20, 8'h3C, 3'd0);
        next_cycle();
        apply_stimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0);
        check_output("wrap_wen",    32'(mem_write_en), 1);
        check_output("wrap_base",   32'(mem_base),     32'hF0);
        check_output("wrap_offset", 32'(mem_offset),   32'h20);
        check_output("wrap_data",   32'(mem_data_in),  32'h3C);
        check_output("wrap_err_ro", 32'(err_ro),       0);
        next_cycle();

        // Store to EA 0x80 must be blocked
        apply_stimulus(1'b1, 1'b1, 8'h70, 8'h10, 8'h99, 3'd0);
        next_cycle();
        apply_stimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0);
        check_output("ro_wen",    32'(mem_write_en), 0);
        check_output("ro_err_ro", 32'(err_ro),       1);
        next_cycle();
        check_output("ro_err_pulse", 32'(err_ro), 0);

        // Load EA 0x10 (via 0x08+0x08) into r1: sees the wrapped store
        apply_stimulus(1'b1, 1'b0, 8'h08, 8'h08, 8'h00, 3'd1);
        next_cycle();
        apply_stimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0);
        next_cycle();
        check_output("wrap_ld_rd",   32'(wb_rd),   1);
        check_output("wrap_ld_data", 32'(wb_data), 32'h3C);
        next_cycle();

        // Load EA 0x80 into r5: read-only region readable, preload 0x80^0x5A untouched
        apply_stimulus(1'b1, 1'b0, 8'h7F, 8'h01, 8'h00, 3'd5);
        next_cycle();
        apply_stimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0);
        check_output("ro_ld_ren", 32'(mem_read_en), 1);
        next_cycle();
        check_output("ro_ld_valid", 32'(wb_valid), 1);
        check_output("ro_ld_rd",    32'(wb_rd),    5);
        check_output("ro_ld_data",  32'(wb_data),  32'hDA);
        next_cycle();

        // req_valid held high, alternating store/load; new request swapped in right after each accept
        write_mark = write_count;
        wb_mark    = wb_count;
        apply_stimulus(1'b1, 1'b1, 8'h20, 8'h00, 8'h11, 3'd0);
        check_output("b2b_rdy0", 32'(req_ready), 1);
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 8'h20, 8'h00, 8'hEE, 3'd2);
        check_output("b2b_rdy1", 32'(req_ready), 0);
        next_cycle();
        check_output("b2b_rdy2", 32'(req_ready), 1);
        next_cycle();
        apply_stimulus(1'b1, 1'b1, 8'h21, 8'h00, 8'h22, 3'd6);
        check_output("b2b_rdy3", 32'(req_ready), 0);
        next_cycle();
        check_output("b2b_rdy4",    32'(req_ready), 0);
        check_output("b2b_wb1_rd",  32'(wb_rd),     2);
        check_output("b2b_wb1_dat", 32'(wb_data),   32'h11);
        next_cycle();
        check_output("b2b_rdy5", 32'(req_ready), 1);
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 8'h21, 8'h00, 8'h00, 3'd4);
        check_output("b2b_rdy6",  32'(req_ready),   0);
        check_output("b2b_st2_d", 32'(mem_data_in), 32'h22);
        next_cycle();
        check_output("b2b_rdy7", 32'(req_ready), 1);
        next_cycle();
        apply_stimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0);
        check_output("b2b_rdy8", 32'(req_ready), 0);
        next_cycle();
        check_output("b2b_rdy9",    32'(req_ready), 0);
        check_output("b2b_wb2_rd",  32'(wb_rd),     4);
        check_output("b2b_wb2_dat", 32'(wb_data),   32'h22);
        next_cycle();
        check_output("b2b_writes", 32'(write_count - write_mark), 2);
        check_output("b2b_wbs",    32'(wb_count - wb_mark),       2);

        // Reset while in STORE: write to 0x30 must not land
        apply_stimulus(1'b1, 1'b1, 8'h00, 8'h30, 8'h77, 3'd0);
        next_cycle();
        apply_stimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0);
        check_output("rst_st_pre_wen", 32'(mem_write_en), 1);
        reset = 1'b1;
        #1;
        check_output("rst_st_wen",   32'(mem_write_en), 0);
        check_output("rst_st_base",  32'(mem_base),     0);
        check_output("rst_st_ready", 32'(req_ready),    0);
        next_cycle();
        reset = 1'b0;
        #1;
        check_output("rst_st_mem_30", 32'(mem[8'h30]), 32'h6A);
        check_output("rst_st_ready1", 32'(req_ready),  1);

        // Reset while in LOAD: no write-back, everything zero
        apply_stimulus(1'b1, 1'b0, 8'h10, 8'h05, 8'h00, 3'd7);
        next_cycle();
        apply_stimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0);
        check_output("rst_ld_pre_ren", 32'(mem_read_en), 1);
        reset = 1'b1;
        #1;
        wb_mark = wb_count;
        check_output("rst_ld_ren",     32'(mem_read_en), 0);
        check_output("rst_ld_offset",  32'(mem_offset),  0);
        check_output("rst_ld_wbv",     32'(wb_valid),    0);
        check_output("rst_ld_wb_data", 32'(wb_data),     0);
        check_output("rst_ld_wb_rd",   32'(wb_rd),       0);
        check_output("rst_ld_ready",   32'(req_ready),   0);
        next_cycle();
        reset = 1'b0;
        #1;
        check_output("rst_ld_ready1",  32'(req_ready), 1);
        check_output("rst_ld_wbv1",    32'(wb_valid),  0);
        check_output("rst_ld_wbdata1", 32'(wb_data),   0);
        next_cycle();
        check_output("rst_ld_wbv2",   32'(wb_valid),          0);
        check_output("rst_ld_ready2", 32'(req_ready),         1);
        check_output("rst_ld_no_wb",  32'(wb_count - wb_mark), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL expose: clk  in  1  clock, all state on rising edge.
REQ-002 SHALL expose: reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL expose: req_valid  in  1  execute stage presents a memory request.
REQ-004 SHALL expose: req_ready  out  1  unit accepts a request this cycle.
REQ-005 SHALL expose: req_is_store  in  1  1=store byte, 0=load byte.
REQ-006 SHALL expose: req_base  in  8  base register value.
REQ-007 SHALL expose: req_offset  in  8  displacement.
REQ-008 SHALL expose: req_store_data  in  8  byte to store.
REQ-009 SHALL expose: req_rd  in  3  load destination register index.
REQ-010 SHALL expose: mem_write_en, mem_read_en  out  1 each  data-memory strobes.
REQ-011 SHALL expose: mem_base, mem_offset, mem_data_in  out  8 each  data-memory address/data.
REQ-012 SHALL expose: mem_data_out  in  8  combinational read data from data memory.
REQ-013 SHALL expose: wb_valid  out  1, wb_rd  out  3, wb_data  out  8  register-file write-back.
REQ-014 SHALL expose: err_ro  out  1  one-cycle pulse, store to read-only region blocked.

Function
REQ-015 SHALL implement FSM states IDLE, STORE, LOAD, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; handshake fires on req_valid && req_ready.
REQ-017 On handshake SHALL latch base, offset, store data, rd, is_store; next state STORE or LOAD.
REQ-018 Effective address EA SHALL be (base + offset) mod 256, 8-bit wrap, no carry kept.
REQ-019 STORE (one cycle): if EA[7]=0, mem_write_en=1 with latched base/offset/data; if EA>=128, mem_write_en=0 and err_ro=1; next IDLE.
REQ-020 LOAD (one cycle): mem_read_en=1 with latched base/offset; wb_data register SHALL capture mem_data_out at end of cycle; next RESP.
REQ-021 RESP (one cycle): wb_valid=1, wb_rd=latched rd, wb_data=captured byte; next IDLE.
REQ-022 Loads from EA>=128 SHALL be permitted (constant region readable).
REQ-023 Latency: store written at edge ending cycle T+1 after handshake at T; load wb_valid in cycle T+2.
REQ-024 Throughput: one store per 2 cycles, one load per 3 cycles; back-to-back accepted only via IDLE.
REQ-025 Outside STORE/LOAD, mem_write_en, mem_read_en, mem_base, mem_offset, mem_data_in SHALL be 0; both strobes never 1 together.
REQ-026 wb_valid and err_ro SHALL be 0 outside RESP and STORE respectively; wb_data SHALL hold last loaded byte.
REQ-027 Store followed immediately by load to same EA SHALL return the stored byte (write lands before LOAD cycle).
REQ-028 Request inputs SHALL be ignored while req_ready=0; no queuing.

Reset
REQ-029 reset SHALL force state IDLE and drop any in-flight request, including one in STORE or LOAD.
REQ-030 During the reset cycle all outputs SHALL be 0 (req_ready included); no memory write SHALL be issued.
REQ-031 wb_data, wb_rd and latched request registers SHALL reset to 0; req_ready=1 first cycle after reset deasserts.

Structure
REQ-032 Shared package lsu_pkg SHALL hold the state enum, RO_BASE = 8'd128, ADDR_W = 8, DATA_W = 8, RD_W = 3.
REQ-033 One combinational sub-module lsu_ea_check SHALL compute EA and the read-only flag.

Verification
REQ-034 Store base=0x10, off=0x05, data=0xA5 -> cycle T+1 mem_write_en=1, mem_base=0x10, mem_offset=0x05, mem_data_in=0xA5; err_ro=0.
REQ-035 Load rd=3 same address, memory model returns 0xA5 -> T+1 mem_read_en=1; T+2 wb_valid=1, wb_rd=3, wb_data=0xA5.
REQ-036 Store base=0xF0, off=0x20 (EA wraps to 0x10) -> write issued; base=0x70, off=0x10 (EA=0x80) -> mem_write_en=0, err_ro=1 one cycle.
REQ-037 req_valid held high with alternating store/load -> req_ready pattern 1,0 (store) and 1,0,0 (load); no request lost or duplicated.
REQ-038 Assert reset during LOAD -> no wb_valid, all outputs 0 that cycle, req_ready=1 next cycle.
